// File: rtl/lsu_pkg.sv
// Shared state type, funct3 codes and request-legality helpers for the
// RV32I load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE,
    RMW_RD,
    RMW_WR,
    RESP
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    logic mis;
    mis = 1'b0;
    case (funct3)
      F3_H, F3_HU: mis = offset[0];
      F3_W:        mis = |offset;
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Stores only know B/H/W; loads additionally allow BU/HU.
  function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
    logic bad;
    if (we) bad = funct3[2] || (funct3[1:0] == 2'b11);
    else    bad = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake and word-memory bus of the load/store unit.
// The master modport is the unit itself; slave is the execute stage plus memory.
interface load_store_unit_if #(
  parameter int MEM_AW = 30
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_addr, mem_re, mem_we, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane handling: load extraction/extension and store merge
// into an old word for read-modify-write.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [31:0] load_data,
  output logic [31:0] merged
);
  logic [31:0] byte_shifted;
  logic [31:0] half_shifted;
  logic [31:0] byte_mask;
  logic [31:0] half_mask;

  assign byte_shifted = rdata >> {offset, 3'b000};
  assign half_shifted = rdata >> {offset[1], 4'b0000};
  assign byte_mask    = 32'h0000_00FF << {offset, 3'b000};
  assign half_mask    = 32'h0000_FFFF << {offset[1], 4'b0000};

  always_comb begin
    load_data = '0;
    case (funct3)
      F3_B:    load_data = {{24{byte_shifted[7]}}, byte_shifted[7:0]};
      F3_BU:   load_data = {24'h0, byte_shifted[7:0]};
      F3_H:    load_data = {{16{half_shifted[15]}}, half_shifted[15:0]};
      F3_HU:   load_data = {16'h0, half_shifted[15:0]};
      F3_W:    load_data = rdata;
      default: load_data = '0;
    endcase
  end

  // Only the addressed lane of the old word is replaced.
  always_comb begin
    merged = wdata;
    case (funct3)
      F3_B:    merged = (old_word & ~byte_mask) | ((wdata & 32'h0000_00FF) << {offset, 3'b000});
      F3_H:    merged = (old_word & ~half_mask) | ((wdata & 32'h0000_FFFF) << {offset[1], 4'b0000});
      default: merged = wdata;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-only memory; sub-word stores are
// performed as read-modify-write, one request in flight at a time.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_AW = 30
) (
  input logic               clk,
  input logic               rstn,
  load_store_unit_if.master bus
);
  state_t            state_q;
  state_t            state_d;
  logic [2:0]        funct3_q;
  logic [MEM_AW+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       buf_q;
  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;
  logic [31:0]       load_data;
  logic [31:0]       merged;
  logic              accept;
  logic              req_err;

  assign accept  = bus.req_valid && (state_q == IDLE);
  assign req_err = is_illegal(bus.req_we, bus.req_funct3)
                || is_misaligned(bus.req_funct3, bus.req_addr[1:0]);

  assign bus.mem_addr  = addr_q[MEM_AW+1:2];
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  lsu_align u_align (
    .rdata     (bus.mem_rdata),
    .old_word  (buf_q),
    .wdata     (wdata_q),
    .funct3    (funct3_q),
    .offset    (addr_q[1:0]),
    .load_data (load_data),
    .merged    (merged)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (accept) begin
          if (req_err)                    state_d = RESP;
          else if (!bus.req_we)           state_d = LOAD;
          else if (bus.req_funct3 == F3_W) state_d = STORE;
          else                            state_d = RMW_RD;
        end
      end
      LOAD: begin
        bus.mem_re = 1'b1;
        state_d    = RESP;
      end
      STORE: begin
        bus.mem_we    = 1'b1;
        bus.mem_wdata = wdata_q;
        state_d       = RESP;
      end
      RMW_RD: begin
        bus.mem_re = 1'b1;
        state_d    = RMW_WR;
      end
      RMW_WR: begin
        bus.mem_we    = 1'b1;
        bus.mem_wdata = merged;
        state_d       = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Response registers only change on the way into RESP, so they hold until the next one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      funct3_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      buf_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        funct3_q <= bus.req_funct3;
        addr_q   <= bus.req_addr[MEM_AW+1:0];
        wdata_q  <= bus.req_wdata;
        if (req_err) begin
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b1;
        end
      end
      case (state_q)
        LOAD: begin
          rsp_rdata_q <= load_data;
          rsp_err_q   <= 1'b0;
        end
        STORE, RMW_WR: begin
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b0;
        end
        RMW_RD: buf_q <= bus.mem_rdata;
        default: ;
      endcase
    end
  end
endmodule
